// File: rtl/mire_gen.sv
// mire_gen: framebuffer test-pattern generator. It runs as a Wishbone classic
// write-only master and fills one HDISP x VDISP frame (32 bits per pixel)
// starting at BASE_ADR. It releases the bus for one cycle after every
// FAIR_PERIOD acknowledged writes so that other masters can use it.
module mire_gen #(
  parameter int              HDISP       = 800,
  parameter int              VDISP       = 480,
  parameter int              GRID        = 16,
  parameter int              FAIR_PERIOD = 64,
  parameter int              ADR_W       = 32,
  parameter logic [ADR_W-1:0] BASE_ADR   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [23:0]      color,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      frame_cnt,
  output logic             wshb_cyc,
  output logic             wshb_stb,
  output logic             wshb_we,
  output logic [3:0]       wshb_sel,
  output logic [2:0]       wshb_cti,
  output logic [1:0]       wshb_bte,
  output logic [ADR_W-1:0] wshb_adr,
  output logic [31:0]      wshb_dat_ms,
  input  logic             wshb_ack
);

  localparam int XW    = $clog2(HDISP);
  localparam int YW    = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int GW    = $clog2(GRID);
  localparam int BAR_W = HDISP / 8;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int FW    = $clog2(FAIR_PERIOD + 1);

  localparam logic [XW-1:0] X_LAST   = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(VDISP - 1);
  localparam logic [GW-1:0] G_LAST   = GW'(GRID - 1);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
  localparam logic [FW-1:0] FAIR_HIT = FW'(FAIR_PERIOD);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_PAUSE} state_e;
  typedef enum logic [1:0] {M_GRID = 2'd0, M_BARS = 2'd1, M_CHECK = 2'd2, M_SOLID = 2'd3} mode_e;

  state_e            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [GW-1:0]     cx_q, cx_d, cy_q, cy_d;
  logic              px_q, px_d, py_q, py_d;
  logic [2:0]        bar_q, bar_d;
  logic [BW-1:0]     bar_cnt_q, bar_cnt_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [FW-1:0]     fair_q, fair_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              frame_done_q, frame_done_d;
  mode_e             mode_q, mode_d;
  logic [23:0]       color_q, color_d;

  logic              last_pix;
  logic [FW-1:0]     fair_inc;
  logic [23:0]       pix_rgb;

  // Register update for the FSM, pixel position, cell/bar counters and status.
  always_ff @(posedge clk) begin
    // NOTE: synchronous reset wins over everything, so an ack sampled together
    // with rst is dropped and the bus is released on the following cycle.
    if (rst) begin
      // NOTE: clocked blocks use non-blocking assignments only, so each flop
      // samples the pre-edge value of every other flop.
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      px_q         <= 1'b0;
      py_q         <= 1'b0;
      bar_q        <= '0;
      bar_cnt_q    <= '0;
      adr_q        <= BASE_ADR;
      fair_q       <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      mode_q       <= M_GRID;
      color_q      <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      px_q         <= px_d;
      py_q         <= py_d;
      bar_q        <= bar_d;
      bar_cnt_q    <= bar_cnt_d;
      adr_q        <= adr_d;
      fair_q       <= fair_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      mode_q       <= mode_d;
      color_q      <= color_d;
    end
  end

  // Next-state logic: start, advance one pixel per ack, fair-play pause, frame wrap.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    px_d         = px_q;
    py_d         = py_q;
    bar_d        = bar_q;
    bar_cnt_d    = bar_cnt_q;
    adr_d        = adr_q;
    fair_d       = fair_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    mode_d       = mode_q;
    color_d      = color_q;
    last_pix     = (x_q == X_LAST) && (y_q == Y_LAST);
    fair_inc     = fair_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d   = S_WRITE;
          mode_d    = mode_e'(mode);
          color_d   = color;
          x_d       = '0;
          y_d       = '0;
          cx_d      = '0;
          cy_d      = '0;
          px_d      = 1'b0;
          py_d      = 1'b0;
          bar_d     = '0;
          bar_cnt_d = '0;
          adr_d     = BASE_ADR;
          fair_d    = '0;
        end
      end

      S_WRITE: begin
        if (wshb_ack) begin
          adr_d = adr_q + ADR_W'(4);

          if (x_q == X_LAST) begin
            // End of line: horizontal counters restart, vertical ones advance.
            x_d       = '0;
            cx_d      = '0;
            px_d      = 1'b0;
            bar_d     = '0;
            bar_cnt_d = '0;
            if (y_q == Y_LAST) begin
              y_d  = '0;
              cy_d = '0;
              py_d = 1'b0;
            end else begin
              y_d = y_q + 1'b1;
              if (cy_q == G_LAST) begin
                cy_d = '0;
                py_d = ~py_q;
              end else begin
                cy_d = cy_q + 1'b1;
              end
            end
          end else begin
            x_d = x_q + 1'b1;
            if (cx_q == G_LAST) begin
              cx_d = '0;
              px_d = ~px_q;
            end else begin
              cx_d = cx_q + 1'b1;
            end
            // The last bar never advances, so it absorbs the HDISP/8 remainder.
            if (bar_q != 3'd7) begin
              if (bar_cnt_q == BAR_LAST) begin
                bar_cnt_d = '0;
                bar_d     = bar_q + 1'b1;
              end else begin
                bar_cnt_d = bar_cnt_q + 1'b1;
              end
            end
          end

          if (fair_inc == FAIR_HIT) begin
            fair_d  = '0;
            state_d = S_PAUSE;
          end else begin
            fair_d = fair_inc;
          end

          if (last_pix) begin
            adr_d        = BASE_ADR;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            if (en) begin
              mode_d  = mode_e'(mode);
              color_d = color;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end

      S_PAUSE: state_d = S_WRITE;

      default: state_d = S_IDLE;
    endcase
  end

  // Pixel colour from the current cell/bar counters and the frame's latched settings.
  always_comb begin
    pix_rgb = 24'h000000;
    unique case (mode_q)
      M_GRID:  if ((cx_q == '0) || (cy_q == '0)) pix_rgb = color_q;
      M_BARS: begin
        case (bar_q)
          3'd0:    pix_rgb = 24'hFFFFFF;
          3'd1:    pix_rgb = 24'hFFFF00;
          3'd2:    pix_rgb = 24'h00FFFF;
          3'd3:    pix_rgb = 24'h00FF00;
          3'd4:    pix_rgb = 24'hFF00FF;
          3'd5:    pix_rgb = 24'hFF0000;
          3'd6:    pix_rgb = 24'h0000FF;
          default: pix_rgb = 24'h000000;
        endcase
      end
      M_CHECK: if (px_q == py_q) pix_rgb = color_q;
      M_SOLID: pix_rgb = color_q;
    endcase
  end

  assign wshb_cyc    = (state_q == S_WRITE);
  assign wshb_stb    = wshb_cyc;
  assign wshb_we     = 1'b1;
  assign wshb_sel    = 4'b0111;
  assign wshb_cti    = 3'b000;
  assign wshb_bte    = 2'b00;
  assign wshb_adr    = adr_q;
  assign wshb_dat_ms = {8'h00, pix_rgb};
  assign busy        = (state_q != S_IDLE);
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
